// File: rtl/signal_demodulator_if.sv
// Bus between the demodulator and its environment: sample/strobe inputs
// toward the demodulator and decided-bit outputs back.
interface signal_demodulator_if;
  logic [1:0]  mod_sel;
  logic        sample_valid;
  logic [11:0] sig_mod;
  logic [11:0] sig;
  logic        bit_strobe;
  logic        bit_out;
  logic        bit_valid;
  logic        short_err;
  logic [15:0] err_count;

  modport master (
    output mod_sel, sample_valid, sig_mod, sig, bit_strobe,
    input  bit_out, bit_valid, short_err, err_count
  );

  modport slave (
    input  mod_sel, sample_valid, sig_mod, sig, bit_strobe,
    output bit_out, bit_valid, short_err, err_count
  );
endinterface

// File: rtl/signal_demodulator.sv
// signal_demodulator: recovers the keying bit from the modulated stream by
// integrating samples over one bit period (closed by bit_strobe) and applying
// a per-mode decision rule. The carrier reference gives coherent BPSK.
// Optional macro DEMOD_ERRCNT_EN enables the saturating error/abort counter;
// without it err_count is tied to zero.
module signal_demodulator #(
  parameter int ACC_W       = 32,
  parameter int CNT_W       = 16,
  parameter int MIN_SAMPLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  signal_demodulator_if.slave  dm
);

  typedef enum logic [0:0] {SYNC = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [1:0]       MODE_ASK  = 2'b00;
  localparam logic [1:0]       MODE_OFF  = 2'b01;
  localparam logic [1:0]       MODE_BPSK = 2'b10;
  localparam logic [1:0]       MODE_FLK  = 2'b11;
  localparam logic [11:0]      SIG_NEG_FS = 12'h800;
  localparam logic [ACC_W-1:0] ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] U_MAX     = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] S_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_SAMPLES);

  // 13-bit magnitude so that -2048 maps to +2048 without overflow.
  function automatic logic [12:0] mag13(input logic [11:0] x);
    if (x[11]) return 13'd0 - {1'b1, x};
    else       return {1'b0, x};
  endfunction

  function automatic logic [ACC_W-1:0] add_usat(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[ACC_W]) return U_MAX;
    else            return sum[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] add_ssat(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) return S_MIN;
      else            return S_MAX;
    end else begin
      return sum[ACC_W-1:0];
    end
  endfunction

  state_t           state_r, state_nxt;
  logic [1:0]       mode_r;
  logic [ACC_W-1:0] acc_a_r, acc_b_r, acc_a_nxt, acc_b_nxt, acc_a_upd, acc_b_upd;
  logic [CNT_W-1:0] cnt_r, cnt_nxt, cnt_upd;
  logic             abort_s, decide_s, bit_dec_s, short_s;
  logic             bit_out_r, bit_valid_r, short_err_r;
  logic [23:0]      prod_s;
  logic [ACC_W-1:0] prod_ext_s, mag_s_ext, mag_r_ext, neg_fs_inc;

  // Coherent product and magnitudes, widened to accumulator width.
  assign prod_s     = {{12{dm.sig_mod[11]}}, dm.sig_mod} * {{12{dm.sig[11]}}, dm.sig};
  assign prod_ext_s = {{(ACC_W-24){prod_s[23]}}, prod_s};
  assign mag_s_ext  = {{(ACC_W-13){1'b0}}, mag13(dm.sig_mod)};
  assign mag_r_ext  = {{(ACC_W-13){1'b0}}, mag13(dm.sig)};
  assign neg_fs_inc = (dm.sig_mod == SIG_NEG_FS) ? ACC_ONE : ACC_ZERO;

  // Next-state, accumulator update and per-mode decision (includes same-cycle sample).
  always_comb begin
    state_nxt = state_r;
    acc_a_nxt = ACC_ZERO;
    acc_b_nxt = ACC_ZERO;
    cnt_nxt   = CNT_ZERO;
    acc_a_upd = acc_a_r;
    acc_b_upd = acc_b_r;
    cnt_upd   = cnt_r;
    abort_s   = 1'b0;
    decide_s  = 1'b0;
    bit_dec_s = 1'b0;
    short_s   = 1'b0;

    if (dm.sample_valid) begin
      if (cnt_r != CNT_MAX) cnt_upd = cnt_r + CNT_ONE;
      else                  cnt_upd = cnt_r;
      case (mode_r)
        MODE_ASK: begin
          acc_a_upd = add_usat(acc_a_r, mag_s_ext);
          acc_b_upd = add_usat(acc_b_r, mag_r_ext);
        end
        MODE_OFF: begin
          acc_a_upd = acc_a_r;
          acc_b_upd = acc_b_r;
        end
        MODE_BPSK: begin
          acc_a_upd = add_ssat(acc_a_r, prod_ext_s);
          acc_b_upd = acc_b_r;
        end
        MODE_FLK: begin
          acc_a_upd = add_usat(acc_a_r, neg_fs_inc);
          acc_b_upd = add_usat(acc_b_r, ACC_ONE);
        end
        default: begin
          acc_a_upd = acc_a_r;
          acc_b_upd = acc_b_r;
        end
      endcase
    end else begin
      cnt_upd = cnt_r;
    end

    case (mode_r)
      MODE_ASK:  bit_dec_s = (acc_a_upd > {1'b0, acc_b_upd[ACC_W-1:1]});
      MODE_OFF:  bit_dec_s = 1'b0;
      MODE_BPSK: bit_dec_s = ($signed(acc_a_upd) > $signed(ACC_ZERO));
      MODE_FLK:  bit_dec_s = !({acc_a_upd, 1'b0} > {1'b0, acc_b_upd});
      default:   bit_dec_s = 1'b0;
    endcase
    short_s = (cnt_upd < CNT_MIN);

    case (state_r)
      SYNC: begin
        // Samples discarded; the first strobe only opens a clean period.
        if (dm.bit_strobe) state_nxt = ACCUM;
        else               state_nxt = SYNC;
      end
      ACCUM: begin
        if (dm.mod_sel != mode_r) begin
          abort_s   = 1'b1;
          state_nxt = SYNC;
        end else if (dm.bit_strobe) begin
          decide_s  = 1'b1;
          state_nxt = ACCUM;
        end else begin
          acc_a_nxt = acc_a_upd;
          acc_b_nxt = acc_b_upd;
          cnt_nxt   = cnt_upd;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= SYNC;
    else       state_r <= state_nxt;
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r      <= MODE_ASK;
      acc_a_r     <= ACC_ZERO;
      acc_b_r     <= ACC_ZERO;
      cnt_r       <= CNT_ZERO;
      bit_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      short_err_r <= 1'b0;
    end else begin
      mode_r      <= dm.mod_sel;
      acc_a_r     <= acc_a_nxt;
      acc_b_r     <= acc_b_nxt;
      cnt_r       <= cnt_nxt;
      bit_valid_r <= decide_s;
      short_err_r <= decide_s & short_s;
      if (decide_s) bit_out_r <= bit_dec_s;
      else          bit_out_r <= bit_out_r;
    end
  end

  assign dm.bit_out   = bit_out_r;
  assign dm.bit_valid = bit_valid_r;
  assign dm.short_err = short_err_r;

`ifdef DEMOD_ERRCNT_EN
  logic [15:0] err_count_r;

  // Saturating count of short periods and mode-change aborts (never both on one edge).
  always_ff @(posedge clk) begin
    if (reset)
      err_count_r <= 16'h0000;
    else if ((abort_s | (decide_s & short_s)) && (err_count_r != 16'hFFFF))
      err_count_r <= err_count_r + 16'h0001;
    else
      err_count_r <= err_count_r;
  end

  assign dm.err_count = err_count_r;
`else
  assign dm.err_count = 16'h0000;
`endif

endmodule
